bsg_mesh_router_input_buffer: RTL and testbench

- Per-direction input buffering stage that sits directly upstream of the mesh router.
- Accepts flits from the P/W/E/N/S links on a valid/ready interface.
- Holds each flit in a small circular FIFO and presents it to the router on the router's valid/yumi input interface (data, v, yumi).
- Decouples link timing from router arbitration and flags link protocol violations per direction.

---
 rtl/bsg_mesh_router_input_buffer_pkg.sv | 21 ++
 rtl/bsg_mesh_router_input_fifo.sv | 75 +++++++
 rtl/bsg_mesh_router_input_buffer.sv | 55 +++++
 tb/tb_bsg_mesh_router_input_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_mesh_router_input_buffer_pkg.sv
// Shared definitions for the mesh router input buffer.
//   dir_e      : direction index order used on every packed per-direction port
//                (P=0, W=1, E=2, N=3, S=4), same order as bsg_noc_pkg.
//   ptr_width  : FIFO pointer width for a given depth (index bits + wrap bit).
package bsg_mesh_router_input_buffer_pkg;

    typedef enum logic [2:0] {
        P = 3'd0,
        W = 3'd1,
        E = 3'd2,
        N = 3'd3,
        S = 3'd4
    } dir_e;

    // The extra MSB is the wrap bit. It separates full from empty when the
    // index bits of the two pointers are equal.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bsg_mesh_router_input_fifo.sv
// Single-direction circular FIFO between one mesh link and the router.
//   clk_i        : clock
//   reset_i      : synchronous reset, active-low
//   link_data_i  : incoming flit
//   link_v_i     : incoming flit valid
//   link_ready_o : FIFO can accept a flit (registered state only)
//   data_o       : head flit (stale contents when v_o=0)
//   v_o          : head flit valid (registered state only)
//   yumi_i       : router consumed the head flit
//   err_o        : sticky flag, link drove valid while ready was low
module bsg_mesh_router_input_fifo
    import bsg_mesh_router_input_buffer_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] link_data_i,
    input  logic               link_v_i,
    output logic               link_ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic               err_o
);

    localparam int ptr_w = ptr_width(els_p);
    localparam int idx_w = ptr_w - 1;

    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [width_p-1:0] mem [els_p];

    logic empty;
    logic full;
    logic enq;
    logic deq;
    logic violation;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[idx_w-1:0] == wr_ptr[idx_w-1:0])
                && (rd_ptr[idx_w] != wr_ptr[idx_w]);

    // Both handshake outputs come from pointers and reset_i only, so a router
    // that raises yumi_i combinationally from v_o cannot close a loop.
    assign link_ready_o = ~full  & reset_i;
    assign v_o          = ~empty & reset_i;
    assign data_o       = mem[rd_ptr[idx_w-1:0]];

    assign enq       = link_v_i & link_ready_o;
    assign deq       = yumi_i   & v_o;
    assign violation = link_v_i & ~link_ready_o & reset_i;

    // NOTE: sequential state uses non-blocking assignments. All updates then
    // see the same pre-edge values, and the order of statements does not matter.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            if (enq)       wr_ptr <= wr_ptr + ptr_w'(1);
            if (deq)       rd_ptr <= rd_ptr + ptr_w'(1);
            if (violation) err_o  <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset. Entries are only read after they
    // are written, because v_o gates them. This keeps the array a plain RAM.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr[idx_w-1:0]] <= link_data_i;
    end

endmodule

// File: rtl/bsg_mesh_router_input_buffer.sv
// Per-direction input buffering stage in front of the mesh router.
//   clk_i        : clock
//   reset_i      : synchronous reset, active-low
//   link_data_i  : dirs_p packed incoming flits, direction d at [d*width_p +: width_p]
//   link_v_i     : incoming flit valid per direction
//   link_ready_o : buffer can accept a flit per direction
//   data_o       : head flit per direction, to router data_i
//   v_o          : head valid per direction, to router v_i
//   yumi_i       : head consumed per direction, from router yumi_o
//   err_o        : sticky link protocol-violation flag per direction
module bsg_mesh_router_input_buffer
    import bsg_mesh_router_input_buffer_pkg::*;
#(
    parameter int width_p = 8,
    parameter int dirs_p  = 5,
    parameter int els_p   = 2,
    parameter bit debug_p = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [dirs_p*width_p-1:0] link_data_i,
    input  logic [dirs_p-1:0]         link_v_i,
    output logic [dirs_p-1:0]         link_ready_o,
    output logic [dirs_p*width_p-1:0] data_o,
    output logic [dirs_p-1:0]         v_o,
    input  logic [dirs_p-1:0]         yumi_i,
    output logic [dirs_p-1:0]         err_o
);

    for (genvar d = 0; d < dirs_p; d++) begin : g_dir
        bsg_mesh_router_input_fifo #(
            .width_p (width_p),
            .els_p   (els_p)
        ) fifo (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .link_data_i  (link_data_i[d*width_p +: width_p]),
            .link_v_i     (link_v_i[d]),
            .link_ready_o (link_ready_o[d]),
            .data_o       (data_o[d*width_p +: width_p]),
            .v_o          (v_o[d]),
            .yumi_i       (yumi_i[d]),
            .err_o        (err_o[d])
        );
    end

    // A yumi with no valid head is ignored by the FIFO. This check only flags
    // the router bug in simulation.
    if (debug_p) begin : g_debug
        a_no_yumi_without_v : assert property (
            @(posedge clk_i) disable iff (!reset_i) ((yumi_i & ~v_o) == '0)
        ) else $error("yumi_i asserted while v_o low: yumi=%b v=%b", yumi_i, v_o);
    end

endmodule

// File: tb/tb_bsg_mesh_router_input_buffer.sv
module tb_bsg_mesh_router_input_buffer;
    import bsg_mesh_router_input_buffer_pkg::*;

    localparam int WIDTH = 8;
    localparam int DIRS  = 5;
    localparam int ELS   = 2;

    logic                  clk_i;
    logic                  reset_i;
    logic [DIRS*WIDTH-1:0] link_data_i;
    logic [DIRS-1:0]       link_v_i;
    logic [DIRS-1:0]       link_ready_o;
    logic [DIRS*WIDTH-1:0] data_o;
    logic [DIRS-1:0]       v_o;
    logic [DIRS-1:0]       yumi_i;
    logic [DIRS-1:0]       err_o;

    bsg_mesh_router_input_buffer #(
        .width_p (WIDTH),
        .dirs_p  (DIRS),
        .els_p   (ELS),
        .debug_p (1'b0)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .link_data_i  (link_data_i),
        .link_v_i     (link_v_i),
        .link_ready_o (link_ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .err_o        (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: one queue of flits per direction plus a sticky error bit.
    logic [WIDTH-1:0] model_q [DIRS][$];
    logic [DIRS-1:0]  model_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [DIRS-1:0] exp_ready;
        logic [DIRS-1:0] exp_v;
        for (int d = 0; d < DIRS; d++) begin
            exp_ready[d] = reset_i && (model_q[d].size() < ELS);
            exp_v[d]     = reset_i && (model_q[d].size() > 0);
        end
        check("link_ready", 64'(link_ready_o), 64'(exp_ready));
        check("v",          64'(v_o),          64'(exp_v));
        check("err",        64'(err_o),        64'(model_err));
        for (int d = 0; d < DIRS; d++) begin
            if (exp_v[d]) check($sformatf("data[%0d]", d), 64'(data_o[d*WIDTH +: WIDTH]), 64'(model_q[d][0]));
        end
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic cycle(input logic rst_n, input logic [DIRS-1:0] lv,
                         input logic [DIRS-1:0] y, input logic [DIRS*WIDTH-1:0] dat);
        reset_i     = rst_n;
        link_v_i    = lv;
        yumi_i      = y;
        link_data_i = dat;
        @(posedge clk_i);
        if (!rst_n) begin
            for (int d = 0; d < DIRS; d++) model_q[d].delete();
            model_err = '0;
        end else begin
            for (int d = 0; d < DIRS; d++) begin
                bit rdy;
                bit vld;
                rdy = model_q[d].size() < ELS;
                vld = model_q[d].size() > 0;
                if (lv[d] && !rdy) model_err[d] = 1'b1;
                if (y[d] && vld)   void'(model_q[d].pop_front());
                if (lv[d] && rdy)  model_q[d].push_back(dat[d*WIDTH +: WIDTH]);
            end
        end
        #1;
        compare_all();
    endtask

    function automatic logic [DIRS*WIDTH-1:0] put(input dir_e d, input logic [WIDTH-1:0] val);
        logic [DIRS*WIDTH-1:0] r;
        r = '0;
        r[int'(d)*WIDTH +: WIDTH] = val;
        return r;
    endfunction

    function automatic logic [DIRS-1:0] bit_of(input dir_e d);
        return DIRS'(1) << int'(d);
    endfunction

    initial begin
        logic [DIRS*WIDTH-1:0] rdat;
        model_err   = '0;
        reset_i     = 1'b0;
        link_v_i    = '0;
        yumi_i      = '0;
        link_data_i = '0;

        // Reset for three cycles, then idle.
        repeat (3) cycle(1'b0, '0, '0, '0);
        cycle(1'b1, '0, '0, '0);
        check("post_reset_ready", 64'(link_ready_o), 64'h1F);
        check("post_reset_v",     64'(v_o),          64'h0);
        check("post_reset_err",   64'(err_o),        64'h0);

        // A single flit on W, then consume it.
        cycle(1'b1, bit_of(W), '0, put(W, 8'h2A));
        check("w_v",    64'(v_o[W]), 64'h1);
        check("w_data", 64'(data_o[int'(W)*WIDTH +: WIDTH]), 64'h2A);
        cycle(1'b1, '0, bit_of(W), '0);
        check("w_v_after_yumi", 64'(v_o[W]), 64'h0);

        // Fill N to full, then pop twice in order.
        cycle(1'b1, bit_of(N), '0, put(N, 8'h11));
        cycle(1'b1, bit_of(N), '0, put(N, 8'h22));
        check("n_full_ready", 64'(link_ready_o[N]), 64'h0);
        check("n_head_first", 64'(data_o[int'(N)*WIDTH +: WIDTH]), 64'h11);
        cycle(1'b1, '0, bit_of(N), '0);
        check("n_ready_after_pop", 64'(link_ready_o[N]), 64'h1);
        check("n_head_second",     64'(data_o[int'(N)*WIDTH +: WIDTH]), 64'h22);
        cycle(1'b1, '0, bit_of(N), '0);

        // Streaming on E with continuous yumi: flits 0..9, wrapping the pointers.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, bit_of(E), bit_of(E), put(E, WIDTH'(i)));
            check("e_stream_ready", 64'(link_ready_o[E]), 64'h1);
            check("e_stream_data",  64'(data_o[int'(E)*WIDTH +: WIDTH]), 64'(i));
        end
        cycle(1'b1, '0, bit_of(E), '0);
        check("e_drained", 64'(v_o[E]), 64'h0);

        // Protocol violation on S: 0xFF pushed into a full FIFO is dropped.
        cycle(1'b1, bit_of(S), '0, put(S, 8'h01));
        cycle(1'b1, bit_of(S), '0, put(S, 8'h02));
        cycle(1'b1, bit_of(S), '0, put(S, 8'hFF));
        check("s_err_set", 64'(err_o[S]), 64'h1);
        cycle(1'b1, '0, bit_of(S), '0);
        cycle(1'b1, '0, bit_of(S), '0);
        check("s_no_ff",     64'(v_o[S]),  64'h0);
        check("s_err_holds", 64'(err_o[S]), 64'h1);
        cycle(1'b0, '0, '0, '0);
        cycle(1'b1, '0, '0, '0);
        check("s_err_cleared", 64'(err_o[S]), 64'h0);

        // Reset mid-stream on P, then a stray yumi and a fresh push.
        cycle(1'b1, bit_of(P), '0, put(P, 8'hA1));
        cycle(1'b1, bit_of(P), '0, put(P, 8'hA2));
        cycle(1'b0, '0, '0, '0);
        cycle(1'b1, '0, bit_of(P), '0);
        check("p_flushed", 64'(v_o[P]), 64'h0);
        cycle(1'b1, bit_of(P), '0, put(P, 8'h5C));
        check("p_after_stray_yumi", 64'(data_o[int'(P)*WIDTH +: WIDTH]), 64'h5C);
        cycle(1'b1, '0, bit_of(P), '0);

        // Randomized traffic. Phases alternate between light and heavy consumer load.
        for (int i = 0; i < 3000; i++) begin
            logic [DIRS-1:0] lv;
            logic [DIRS-1:0] y;
            logic            rst_n;
            for (int d = 0; d < DIRS; d++) rdat[d*WIDTH +: WIDTH] = WIDTH'($urandom);
            lv    = DIRS'($urandom);
            y     = ((i / 100) % 2 == 0) ? DIRS'($urandom) : DIRS'($urandom & $urandom);
            rst_n = ($urandom_range(0, 79) != 0);
            cycle(rst_n, lv, y, rdat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
